imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
Fetch sequencer for the single-port, combinationally read 256-word instruction memory.
- Owns the program counter and drives the memory word address.
- Registers the returned instruction, with its PC, into a valid/ready output stage toward decode.
- Handles backpressure, branch/jump redirects with flush, and a sticky fault on misaligned or out-of-range fetch addresses.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- MEM_WORDS, 256, instruction memory depth in 32-bit words. Legal PC range is 0 to MEM_WORDS*4-4.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- imem_addr  output  32  byte address to instruction memory; equals pc_q.
- imem_instr  input  32  combinational read data for imem_addr.
- redirect_valid  input  1  taken branch/jump from execute; single-cycle pulse or level.
- redirect_pc  input  32  redirect target byte address.
- out_valid  output  1  out_instr/out_pc hold a valid fetched instruction.
- out_ready  input  1  decode accepts the output this cycle.
- out_instr  output  32  fetched instruction.
- out_pc  output  32  byte address of out_instr.
- fault  output  1  sticky fetch fault.
- fault_pc  output  32  offending address captured on fault entry.

Behaviour:
- States: BOOT, RUN, FAULT. All state changes happen on the clk edge.
- Reset (rst_n=0 at an edge):
  - state=BOOT, pc_q=RESET_PC.
  - out_valid=0, out_instr=0, out_pc=0, fault=0, fault_pc=0.
  - Reset asserted mid-operation discards all in-flight state on that edge.
- BOOT: lasts one cycle with out_valid=0, then goes to RUN. Unconditional unless redirect_valid=1, which applies the redirect rule below.
- RUN fetch condition:
  - fetch_en = (!out_valid || out_ready) && !redirect_valid.
  - When fetch_en=1:
    - out_instr <= imem_instr, out_pc <= pc_q, out_valid <= 1.
    - pc_q <= pc_q + 4.
  - When out_valid=1 and out_ready=1 but no new fetch occurs: out_valid <= 0.
  - When out_valid=1 and out_ready=0: out_instr, out_pc and pc_q are held stable. Decode must never see the data change while valid is high without a handshake.
- Redirect (redirect_valid=1, BOOT or RUN):
  - Highest priority.
  - out_valid <= 0; the held instruction is flushed even if out_ready=1 that cycle.
  - pc_q <= redirect_pc. Fetching resumes on the next cycle.
  - Redirect-to-output latency is 2 edges.
- Range check:
  - Bad address: addr[1:0] != 0, or addr[31:2] >= MEM_WORDS.
  - Checked on redirect_pc when a redirect is accepted.
  - Checked on pc_q before each fetch, which covers sequential run-off past the last word. There is no wrap-around.
  - On a bad address: state <= FAULT, fault <= 1, fault_pc <= bad address, out_valid <= 0, and no fetch is issued.
- FAULT:
  - Terminal until reset. out_valid=0, pc_q frozen.
  - redirect_valid and out_ready are ignored.
- imem_addr is always pc_q, including in BOOT and FAULT. Memory reads have no side effects.
- Arithmetic:
  - The PC increment is a 32-bit add.
  - The overflow case is unreachable because of the range check. Any PC that is reachable and in range cannot overflow.
- Throughput: 1 instruction/cycle with out_ready held high.
- First out_valid appears on the 2nd edge after rst_n rises: 1 edge leaving BOOT, 1 edge fetching.

Decomposition:
- Shared package (rv32_pkg):
  - XLEN=32, INSTR_NOP=32'h0000_0013.
  - Fetch state enum {BOOT, RUN, FAULT}.
  - Address-range check function addr_ok(addr, words).
- One natural sub-module, fetch_out_reg: the valid/ready output register holding instr+pc with flush and load controls.
- PC and FSM stay in the top module.

Test Plan:
- Memory word0=0x00100093, word1=0x00200113; reset release, out_ready=1.
  - Required: out_valid rises on edge 2 with out_pc=0x0, out_instr=0x00100093.
  - Next edge: out_pc=0x4, out_instr=0x00200113, one per cycle.
- Backpressure: hold out_ready=0 for 3 cycles at out_pc=0x8.
  - Required: out_instr/out_pc stable at 0x8/word2 while stalled.
  - On release: the next beat is 0xC, with no skipped or duplicated PC.
- Redirect with a valid output pending (out_pc=0x10, out_ready=1), redirect_pc=0x40.
  - Required: out_valid=0 next cycle, then out_pc=0x40.
  - The 0x10 instruction is never handshaken.
- Misaligned redirect_pc=0x42.
  - Required: fault=1 and fault_pc=0x42 next edge, out_valid stays 0.
  - Later redirect_pc=0x0 is ignored; only rst_n=0 clears the fault.
- Sequential run-off: redirect to 0x3FC (last word) with out_ready=1.
  - Required: 0x3FC is delivered.
  - Next cycle: fault=1 with fault_pc=0x400, no further out_valid.
- Reset mid-stall: with out_valid=1 and out_ready=0, pulse rst_n=0 for one edge.
  - Required: out_valid=0 and pc_q=RESET_PC.
  - Fetch restarts from 0x0 per the first scenario.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 fetch definitions: word size, fetch FSM states and the
// instruction-memory address legality check.
package rv32_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FAULT
  } fetch_state_e;

  // A fetch address is legal when word-aligned and inside the memory depth.
  function automatic logic addr_ok(input logic [XLEN-1:0] addr,
                                   input logic [XLEN-1:0] words);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[XLEN-1:2]} < words);
  endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready output stage toward decode: holds one fetched instruction and
// its PC, with a flush that beats a load and a handshake that drains it.
module fetch_out_reg
  import rv32_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            load,
  input  logic            ready,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  // Payload only changes on a load, so a stalled beat stays stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer for a combinationally read instruction memory: owns the PC,
// handles redirects and backpressure, and latches a sticky fault on bad addresses.
module imem_fetch_ctrl
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam logic [XLEN-1:0] WORDS = XLEN'(MEM_WORDS);

  fetch_state_e    state;
  logic [XLEN-1:0] pc_q;

  logic redirect_take;
  logic redirect_bad;
  logic fetch_try;
  logic pc_bad;
  logic fetch_go;
  logic fault_entry;
  logic flush;

  // Redirects outrank fetching; a bad address anywhere kills the output stage.
  always_comb begin
    redirect_take = (state != FAULT) && redirect_valid;
    redirect_bad  = !addr_ok(redirect_pc, WORDS);
    fetch_try     = (state == RUN) && !redirect_valid && (!out_valid || out_ready);
    pc_bad        = !addr_ok(pc_q, WORDS);
    fetch_go      = fetch_try && !pc_bad;
    fault_entry   = (redirect_take && redirect_bad) || (fetch_try && pc_bad);
    flush         = redirect_take || fault_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc_q     <= RESET_PC;
      fault    <= 1'b0;
      fault_pc <= '0;
    end else begin
      case (state)
        BOOT, RUN: begin
          if (redirect_take) begin
            if (redirect_bad) begin
              state    <= FAULT;
              fault    <= 1'b1;
              fault_pc <= redirect_pc;
            end else begin
              state <= RUN;
              pc_q  <= redirect_pc;
            end
          end else if (state == BOOT) begin
            state <= RUN;
          end else if (fetch_try) begin
            // The range check stops the PC before the add could ever wrap.
            if (pc_bad) begin
              state    <= FAULT;
              fault    <= 1'b1;
              fault_pc <= pc_q;
            end else begin
              pc_q <= pc_q + 32'd4;
            end
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

  assign imem_addr = pc_q;

  fetch_out_reg u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .load       (fetch_go),
    .ready      (out_ready),
    .load_instr (imem_instr),
    .load_pc    (pc_q),
    .valid      (out_valid),
    .instr      (out_instr),
    .pc         (out_pc)
  );

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: expected beats are queued as stimulus
// is driven and matched against the output stage at every falling edge.
module tb_imem_fetch_ctrl;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;

  logic [31:0] mem [256];
  beat_t       sb_q[$];
  int          num_checks;
  int          num_errors;

  imem_fetch_ctrl #(
    .RESET_PC  (32'h0000_0000),
    .MEM_WORDS (256)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_instr = (imem_addr[31:10] == 22'd0) ? mem[imem_addr[9:2]] : 32'h0;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic rv, input logic [31:0] rpc);
    out_ready      = ready;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic pushBeat(input logic [31:0] pc);
    beat_t b;
    b.pc    = pc;
    b.instr = mem[pc[9:2]];
    sb_q.push_back(b);
  endtask

  task automatic waitForPc(input logic [31:0] target, input int budget, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clk);
      #1;
      if (out_valid && out_pc == target) found = 1'b1;
    end
    checkOutput(tag, {31'b0, found}, 32'd1);
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  // Falling-edge monitor: every valid beat must match the scoreboard head;
  // the head retires on a handshake or when a redirect flushes it.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb_q.size() == 0) begin
        checkOutput("beat_unexpected", {31'b0, out_valid}, 32'd0);
      end else begin
        checkOutput("beat_pc", out_pc, sb_q[0].pc);
        checkOutput("beat_instr", out_instr, sb_q[0].instr);
        if (redirect_valid || out_ready) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    num_checks = 0;
    num_errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i * 3);
    mem[0] = 32'h0010_0093;
    mem[1] = 32'h0020_0113;
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;

    checkOutput("reset_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_instr", out_instr, 32'h0);
    checkOutput("reset_out_pc", out_pc, 32'h0);
    checkOutput("reset_fault", {31'b0, fault}, 32'd0);
    checkOutput("reset_fault_pc", fault_pc, 32'h0);
    checkOutput("reset_imem_addr", imem_addr, 32'h0);

    // Streaming from reset, then a 3-cycle stall at 0x8.
    for (int a = 0; a <= 16; a += 4) pushBeat(32'(a));
    rst_n = 1'b1;
    stepEdge();
    checkOutput("boot_valid", {31'b0, out_valid}, 32'd0);
    stepEdge();
    checkOutput("first_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("first_pc", out_pc, 32'h0);
    checkOutput("first_instr", out_instr, 32'h0010_0093);
    stepEdge();
    checkOutput("second_pc", out_pc, 32'h4);
    checkOutput("second_instr", out_instr, 32'h0020_0113);
    waitForPc(32'h8, 10, "wait_pc8");
    applyStimulus(1'b0, 1'b0, 32'h0);
    repeat (3) stepEdge();
    checkOutput("stall_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("stall_pc", out_pc, 32'h8);
    checkOutput("stall_instr", out_instr, mem[2]);
    applyStimulus(1'b1, 1'b0, 32'h0);
    stepEdge();
    checkOutput("after_stall_pc", out_pc, 32'hC);

    // Redirect while 0x10 is on the output with ready high.
    waitForPc(32'h10, 10, "wait_pc10");
    applyStimulus(1'b1, 1'b1, 32'h40);
    pushBeat(32'h40);
    stepEdge();
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("redirect_flush", {31'b0, out_valid}, 32'd0);
    stepEdge();
    checkOutput("redirect_valid_out", {31'b0, out_valid}, 32'd1);
    checkOutput("redirect_target", out_pc, 32'h40);

    // Misaligned redirect enters a fault that later redirects cannot clear.
    applyStimulus(1'b1, 1'b1, 32'h42);
    stepEdge();
    applyStimulus(1'b1, 1'b1, 32'h0);
    checkOutput("misalign_fault", {31'b0, fault}, 32'd1);
    checkOutput("misalign_fault_pc", fault_pc, 32'h42);
    checkOutput("misalign_valid", {31'b0, out_valid}, 32'd0);
    stepEdge();
    applyStimulus(1'b0, 1'b0, 32'h0);
    stepEdge();
    applyStimulus(1'b1, 1'b0, 32'h0);
    repeat (3) stepEdge();
    checkOutput("fault_sticky", {31'b0, fault}, 32'd1);
    checkOutput("fault_pc_sticky", fault_pc, 32'h42);
    checkOutput("fault_no_valid", {31'b0, out_valid}, 32'd0);

    // Redirect during BOOT to the last word, then run off the end.
    rst_n = 1'b0;
    sb_q.delete();
    stepEdge();
    checkOutput("reset_clears_fault", {31'b0, fault}, 32'd0);
    checkOutput("reset_clears_fault_pc", fault_pc, 32'h0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'h3FC);
    pushBeat(32'h3FC);
    stepEdge();
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("runoff_boot_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("runoff_addr", imem_addr, 32'h3FC);
    stepEdge();
    checkOutput("runoff_last_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("runoff_last_pc", out_pc, 32'h3FC);
    stepEdge();
    checkOutput("runoff_fault", {31'b0, fault}, 32'd1);
    checkOutput("runoff_fault_pc", fault_pc, 32'h400);
    checkOutput("runoff_valid", {31'b0, out_valid}, 32'd0);
    repeat (3) stepEdge();
    checkOutput("runoff_drained", 32'(sb_q.size()), 32'd0);

    // Reset pulse while a beat is stalled, then a clean restart from 0x0.
    rst_n = 1'b0;
    sb_q.delete();
    stepEdge();
    rst_n = 1'b1;
    pushBeat(32'h0);
    pushBeat(32'h4);
    waitForPc(32'h4, 10, "wait_pc4");
    applyStimulus(1'b0, 1'b0, 32'h0);
    repeat (2) stepEdge();
    checkOutput("prestall_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("prestall_pc", out_pc, 32'h4);
    rst_n = 1'b0;
    sb_q.delete();
    stepEdge();
    checkOutput("midreset_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midreset_addr", imem_addr, 32'h0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0);
    pushBeat(32'h0);
    pushBeat(32'h4);
    stepEdge();
    checkOutput("restart_boot_valid", {31'b0, out_valid}, 32'd0);
    stepEdge();
    checkOutput("restart_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("restart_pc", out_pc, 32'h0);
    checkOutput("restart_instr", out_instr, 32'h0010_0093);
    waitForPc(32'h4, 5, "wait_restart_pc4");
    applyStimulus(1'b0, 1'b0, 32'h0);
    repeat (2) stepEdge();
    checkOutput("restart_pending", 32'(sb_q.size()), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
